// File: rtl/tx_fifo_drain_ctrl.sv
// TX_CLK-domain drain controller: moves FIFO head words into the UART transmitter and
// pops each word only after the transmitter has visibly started sending it.
module tx_fifo_drain_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int TW         = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  TX_CLK,
    input  logic                  RST,
    input  logic                  EN,
    input  logic                  RD_EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_DATA_VALID,
    output logic                  RINC,
    output logic                  ERR,
    input  logic                  ERR_CLR,
    output logic [CNT_WIDTH-1:0]  SENT_CNT
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_BUSY = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

    logic [1:0]            state_q,   state_d;
    logic [TW-1:0]         cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  valid_q,   valid_d;
    logic                  rinc_q,    rinc_d;
    logic                  err_q,     err_d;
    logic [CNT_WIDTH-1:0]  sent_q,    sent_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_data_d = tx_data_q;
        valid_d   = 1'b0;
        rinc_d    = 1'b0;
        err_d     = err_q;
        sent_d    = sent_q;

        // Clear first so a timeout on the same edge overrides it.
        if (ERR_CLR) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (EN && !RD_EMPTY && !TX_BUSY) begin
                    tx_data_d = RD_DATA;
                    valid_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    rinc_d  = 1'b1;
                    state_d = WAIT_DONE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    sent_d  = sent_q + CNT_WIDTH'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge TX_CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tx_data_q <= '0;
            valid_q   <= 1'b0;
            rinc_q    <= 1'b0;
            err_q     <= 1'b0;
            sent_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_data_q <= tx_data_d;
            valid_q   <= valid_d;
            rinc_q    <= rinc_d;
            err_q     <= err_d;
            sent_q    <= sent_d;
        end
    end

    assign TX_DATA       = tx_data_q;
    assign TX_DATA_VALID = valid_q;
    assign RINC          = rinc_q;
    assign ERR           = err_q;
    assign SENT_CNT      = sent_q;

endmodule

// File: tb/tb_tx_fifo_drain_ctrl.sv
// Randomized bench for tx_fifo_drain_ctrl against a transaction-level model of the
// FIFO queue, the transmitter handshake and the busy-timeout.
module tb_tx_fifo_drain_ctrl;

    localparam int DW = 8;
    localparam int TO = 16;
    localparam int TW = 5;
    localparam int CW = 8;

    logic          TX_CLK   = 1'b0;
    logic          RST      = 1'b0;
    logic          EN       = 1'b0;
    logic          RD_EMPTY = 1'b1;
    logic [DW-1:0] RD_DATA  = '0;
    logic          TX_BUSY  = 1'b0;
    logic          ERR_CLR  = 1'b0;
    logic [DW-1:0] TX_DATA;
    logic          TX_DATA_VALID;
    logic          RINC;
    logic          ERR;
    logic [CW-1:0] SENT_CNT;

    tx_fifo_drain_ctrl #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO),
        .TW         (TW),
        .CNT_WIDTH  (CW)
    ) dut (
        .TX_CLK        (TX_CLK),
        .RST           (RST),
        .EN            (EN),
        .RD_EMPTY      (RD_EMPTY),
        .RD_DATA       (RD_DATA),
        .TX_BUSY       (TX_BUSY),
        .TX_DATA       (TX_DATA),
        .TX_DATA_VALID (TX_DATA_VALID),
        .RINC          (RINC),
        .ERR           (ERR),
        .ERR_CLR       (ERR_CLR),
        .SENT_CNT      (SENT_CNT)
    );

    always #5 TX_CLK = ~TX_CLK;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    // Reference model: a queue for the FIFO plus the record of the word in flight.
    logic [DW-1:0] fifo[$];
    bit            in_flight = 0;
    bit            accepted  = 0;
    int            load_edge = 0;
    logic [DW-1:0] m_data    = '0;
    bit            m_valid   = 0;
    bit            m_rinc    = 0;
    bit            m_err     = 0;
    int            m_sent    = 0;

    // Observations of the DUT, used only for scenario-level checks.
    int            obs_valid = 0;
    int            obs_rinc  = 0;
    logic [DW-1:0] last_valid_data = '0;
    int            last_valid_edge = -1;
    int            err_edge  = -1;
    bit            err_prev  = 0;

    // Transmitter model.
    int tx_mode   = 0;   // 0 responsive, 1 ignores valid, 2 random busy
    int rise_dly  = 2;
    int hold_len  = 10;
    bit rand_tx   = 0;
    int wait_left = 0;
    int hold_left = 0;
    bit clr_at_timeout = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        in_flight = 0;
        accepted  = 0;
        m_data    = '0;
        m_valid   = 0;
        m_rinc    = 0;
        m_err     = 0;
        m_sent    = 0;
    endtask

    task automatic model_edge();
        bit set_err;
        set_err = 0;
        m_valid = 0;
        m_rinc  = 0;
        if (!RST) begin
            model_reset();
            return;
        end
        if (!in_flight) begin
            if (EN && !RD_EMPTY && !TX_BUSY) begin
                m_data    = fifo[0];
                m_valid   = 1;
                in_flight = 1;
                accepted  = 0;
                load_edge = edge_n;
            end
        end else if (!accepted) begin
            if (TX_BUSY) begin
                m_rinc   = 1;
                accepted = 1;
                void'(fifo.pop_front());
            end else if (edge_n - load_edge == TO) begin
                set_err   = 1;
                in_flight = 0;
            end
        end else if (!TX_BUSY) begin
            m_sent    = (m_sent + 1) % (1 << CW);
            in_flight = 0;
        end
        if (set_err) m_err = 1;
        else if (ERR_CLR) m_err = 0;
    endtask

    task automatic compare_outputs();
        check_eq("valid",   32'(TX_DATA_VALID), 32'(m_valid));
        check_eq("rinc",    32'(RINC),          32'(m_rinc));
        check_eq("err",     32'(ERR),           32'(m_err));
        check_eq("sent",    32'(SENT_CNT),      32'(m_sent));
        check_eq("tx_data", 32'(TX_DATA),       32'(m_data));
        if (TX_DATA_VALID === 1'b1) begin
            obs_valid++;
            last_valid_data = TX_DATA;
            last_valid_edge = edge_n;
        end
        if (RINC === 1'b1) obs_rinc++;
        if (ERR === 1'b1 && !err_prev) err_edge = edge_n;
        err_prev = (ERR === 1'b1);
    endtask

    task automatic drive_fifo();
        RD_EMPTY = (fifo.size() == 0);
        RD_DATA  = (fifo.size() != 0) ? fifo[0] : DW'($urandom);
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo.push_back(w);
        drive_fifo();
    endtask

    task automatic set_tx_mode(input int m);
        tx_mode   = m;
        wait_left = 0;
        hold_left = 0;
        TX_BUSY   = 1'b0;
    endtask

    task automatic tx_react();
        if (tx_mode == 2) begin
            if ($urandom_range(0, 3) == 0) TX_BUSY = ~TX_BUSY;
            return;
        end
        if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) TX_BUSY = 1'b0;
        end else if (wait_left > 0) begin
            wait_left--;
            if (wait_left == 0) begin
                TX_BUSY   = 1'b1;
                hold_left = hold_len;
            end
        end else if (m_valid && tx_mode == 0) begin
            if (rand_tx) begin
                rise_dly = $urandom_range(1, 3);
                hold_len = $urandom_range(1, 5);
            end
            if (rise_dly <= 1) begin
                TX_BUSY   = 1'b1;
                hold_left = hold_len;
            end else begin
                wait_left = rise_dly - 1;
            end
        end
    endtask

    task automatic step();
        @(posedge TX_CLK);
        edge_n++;
        model_edge();
        @(negedge TX_CLK);
        compare_outputs();
    endtask

    task automatic tick();
        step();
        tx_react();
        if (clr_at_timeout)
            ERR_CLR = (in_flight && !accepted && (edge_n - load_edge == TO - 1));
        drive_fifo();
    endtask

    task automatic apply_reset(input int cycles);
        RST = 1'b0;
        set_tx_mode(tx_mode);
        #1;
        model_reset();
        compare_outputs();
        repeat (cycles) step();
        RST = 1'b1;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (fifo.size() == 0 && !in_flight) break;
            tick();
        end
        check_eq(tag, 32'(fifo.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int            sent_before;
        int            valid_before;
        int            rinc_before;
        int            load_at;

        // Reset held with random inputs: every output must stay zero.
        for (int i = 0; i < 6; i++) begin
            EN       = 1'($urandom);
            TX_BUSY  = 1'($urandom);
            ERR_CLR  = 1'($urandom);
            RD_EMPTY = 1'($urandom);
            RD_DATA  = DW'($urandom);
            step();
        end
        check_eq("rst_data", 32'(TX_DATA), 32'd0);
        check_eq("rst_cnt",  32'(SENT_CNT), 32'd0);

        ERR_CLR = 1'b0;
        EN      = 1'b1;
        set_tx_mode(0);
        drive_fifo();
        RST = 1'b1;
        repeat (20) tick();
        check_eq("idle_no_valid", 32'(obs_valid), 32'd0);

        // Single word with busy two cycles after valid, held ten cycles.
        rise_dly = 2;
        hold_len = 10;
        push_word(8'hA5);
        run_until_idle(60, "single_drain");
        check_eq("single_data",  32'(last_valid_data), 32'hA5);
        check_eq("single_valid", 32'(obs_valid), 32'd1);
        check_eq("single_rinc",  32'(obs_rinc),  32'd1);
        check_eq("single_sent",  32'(SENT_CNT),  32'd1);

        // Burst of 300 words from a fresh counter, wrapping SENT_CNT.
        apply_reset(2);
        obs_rinc  = 0;
        obs_valid = 0;
        rand_tx   = 1;
        for (int i = 0; i < 300; i++) fifo.push_back(DW'(i));
        drive_fifo();
        run_until_idle(300 * 12, "burst_drain");
        check_eq("burst_rinc",  32'(obs_rinc),  32'd300);
        check_eq("burst_valid", 32'(obs_valid), 32'd300);
        check_eq("burst_sent",  32'(SENT_CNT),  32'(300 % 256));
        check_eq("burst_last",  32'(last_valid_data), 32'(299 % 256));
        rand_tx = 0;

        // Timeout: transmitter ignores the load.
        set_tx_mode(1);
        obs_rinc = 0;
        err_edge = -1;
        push_word(8'h3C);
        load_at = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (TX_DATA_VALID === 1'b1 && load_at < 0) load_at = edge_n;
            if (ERR === 1'b1) break;
        end
        check_eq("to_edge", 32'(err_edge - load_at), 32'(TO));
        check_eq("to_rinc", 32'(obs_rinc), 32'd0);
        set_tx_mode(0);
        rise_dly = 2;
        hold_len = 3;
        run_until_idle(80, "retry_drain");
        check_eq("retry_data", 32'(last_valid_data), 32'h3C);
        check_eq("retry_rinc", 32'(obs_rinc), 32'd1);
        check_eq("err_sticky", 32'(ERR), 32'd1);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check_eq("err_clr", 32'(ERR), 32'd0);

        // ERR_CLR on the timeout edge: the set must win.
        set_tx_mode(1);
        clr_at_timeout = 1;
        push_word(8'h77);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ERR === 1'b1) break;
        end
        check_eq("sim_err", 32'(ERR), 32'd1);
        clr_at_timeout = 0;
        ERR_CLR = 1'b0;
        set_tx_mode(0);
        run_until_idle(80, "sim_drain");

        // EN dropped while the frame is on the line.
        sent_before  = m_sent;
        hold_len     = 6;
        rise_dly     = 1;
        fifo.push_back(8'h11);
        push_word(8'h22);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (RINC === 1'b1) break;
        end
        EN = 1'b0;
        valid_before = obs_valid;
        repeat (30) tick();
        check_eq("endrop_sent",   32'(SENT_CNT), 32'((sent_before + 1) % 256));
        check_eq("endrop_noload", 32'(obs_valid - valid_before), 32'd0);
        EN = 1'b1;
        run_until_idle(60, "endrop_drain");
        check_eq("endrop_tail", 32'(last_valid_data), 32'h22);

        // Reset while waiting for busy: the word must not be popped.
        set_tx_mode(1);
        rinc_before = obs_rinc;
        push_word(8'h5A);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (TX_DATA_VALID === 1'b1) break;
        end
        repeat (3) tick();
        apply_reset(2);
        check_eq("rstmid_rinc", 32'(obs_rinc - rinc_before), 32'd0);
        set_tx_mode(0);
        rise_dly = 2;
        hold_len = 4;
        drive_fifo();
        run_until_idle(60, "rstmid_drain");
        check_eq("rstmid_reload", 32'(last_valid_data), 32'h5A);
        check_eq("rstmid_rinc2",  32'(obs_rinc - rinc_before), 32'd1);

        // Mixed random traffic with random transmitter behaviour.
        for (int seg = 0; seg < 15; seg++) begin
            set_tx_mode($urandom_range(0, 2));
            rand_tx = 1;
            for (int i = 0; i < 200; i++) begin
                EN      = ($urandom_range(0, 7) != 0);
                ERR_CLR = ($urandom_range(0, 31) == 0);
                if ($urandom_range(0, 2) == 0 && fifo.size() < 6) fifo.push_back(DW'($urandom));
                drive_fifo();
                tick();
            end
        end
        ERR_CLR = 1'b0;
        EN      = 1'b1;
        set_tx_mode(0);
        run_until_idle(600, "rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
